// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One extra bit keeps the counter non-zero width when the operand is a single bit.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, reused every cycle by the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first over WIDTH cycles.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on start
//   RUN   | one operand bit per cycle through the cell, carry held in a flop
//   DONE  | result valid for one cycle; start here begins the next addition
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_shift;
   logic [CW-1:0]    count;
   logic             carry;
   logic             fa_s;
   logic             fa_cout;
   logic             last;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
   assign s_shift = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   assign last    = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         count <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  count <= '0;
               end
            end
            RUN: begin
               carry <= fa_cout;
               s_sr  <= s_shift;
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               count <= count + 1'b1;
               if (last) begin
                  sum  <= s_shift;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// compared against plain a+b+cin arithmetic.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;

   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic         start1 = 1'b0;
   logic         a1 = 1'b0;
   logic         b1 = 1'b0;
   logic         cin1 = 1'b0;
   logic         busy1;
   logic         done1;
   logic         sum1;
   logic         cout1;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [W-1:0] exp_sum = '0;
   logic         exp_cout = 1'b0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start1),
      .a       (a1),
      .b       (b1),
      .cin     (cin1),
      .busy    (busy1),
      .done    (done1),
      .sum     (sum1),
      .cout    (cout1)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one addition from the current cycle and checks every cycle up to the
   // done cycle, where it returns. With hold set, start stays high during RUN
   // while decoy operands are presented.
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                     input bit hold);
      logic [W:0] e;
      e = ta + tb_ + tc;
      start = 1'b1;
      a     = ta;
      b     = tb_;
      cin   = tc;
      step();
      if (hold) begin
         a   = W'(8'hAA);
         b   = W'(8'h55);
         cin = 1'b1;
      end else begin
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         cin   = 1'($urandom);
      end
      for (int i = 1; i <= W; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_held", sum, exp_sum);
         chk("cout_held", cout, exp_cout);
         step();
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", sum, e[W-1:0]);
      chk("cout", cout, e[W]);
      exp_sum  = e[W-1:0];
      exp_cout = e[W];
   endtask

   initial begin
      logic [1:0] e1;
      logic       ra, rb, rc;

      reset_n = 1'b0;
      repeat (2) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_busy1", busy1, 0);
      reset_n = 1'b1;
      step();
      chk("idle_done", done, 0);

      op(8'h03, 8'h05, 1'b0, 1'b0);
      step();
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);

      op(8'hFF, 8'h01, 1'b0, 1'b0);
      step();
      op(8'hFF, 8'hFF, 1'b1, 1'b0);
      step();

      // start held through RUN with decoy operands
      op(8'h10, 8'h20, 1'b0, 1'b1);
      start = 1'b0;
      step();
      chk("no_extra_busy", busy, 0);
      chk("no_extra_done", done, 0);

      // back-to-back with start held high throughout
      op(8'h7F, 8'h01, 1'b0, 1'b1);
      op(8'hC8, 8'h64, 1'b0, 1'b1);
      start = 1'b0;
      step();
      chk("b2b_idle", busy, 0);

      // reset at T+4 aborts the operation
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      cin   = 1'b0;
      step();
      start = 1'b0;
      repeat (3) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      exp_sum  = '0;
      exp_cout = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("abort_no_done", done, 0);
         step();
      end
      op(8'h12, 8'h34, 1'b0, 1'b0);
      step();

      // single-bit instance
      start1 = 1'b1;
      a1     = 1'b1;
      b1     = 1'b1;
      cin1   = 1'b1;
      step();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      step();
      chk("w1_done", done1, 1);
      chk("w1_sum", sum1, 1);
      chk("w1_cout", cout1, 1);
      step();
      chk("w1_done_once", done1, 0);
      for (int k = 0; k < 20; k++) begin
         ra     = 1'($urandom);
         rb     = 1'($urandom);
         rc     = 1'($urandom);
         e1     = ra + rb + rc;
         start1 = 1'b1;
         a1     = ra;
         b1     = rb;
         cin1   = rc;
         step();
         start1 = 1'b0;
         a1     = 1'($urandom);
         b1     = 1'($urandom);
         step();
         chk("w1r_done", done1, 1);
         chk("w1r_sum", sum1, e1[0]);
         chk("w1r_cout", cout1, e1[1]);
         step();
      end

      // randomized operations, with and without idle gaps
      for (int k = 0; k < 1000; k++) begin
         op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         if ($urandom_range(1) == 0) begin
            step();
            chk("rand_gap_done", done, 0);
         end
      end
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
